sha2_stream: RTL and testbench
==============================

# sha2_stream

Multi-block, parametrised SHA-2 hashing engine with valid/ready handshakes. It accepts pre-padded message blocks and drives one `sha256_block` or `sha512_block` compression core. It chains the intermediate hash across blocks and returns a (optionally truncated) digest once the final block completes. It sits between a padding/framing front end and digest consumers, replacing ad-hoc single-block drive of the cores.

## Interface

- `VARIANT`, 256: selects the core. 256 selects `sha256_block`, with STATE_BITS=256 and BLOCK_BITS=512. 512 selects `sha512_block`, with STATE_BITS=512 and BLOCK_BITS=1024. Any other value is an elaboration error.
- `OUT_BITS`, VARIANT: digest width, 1..STATE_BITS. 224 gives SHA-224; 384 gives SHA-384.
- `CUSTOM_IV`, 0: 0 uses the internal `sha256_H_0`/`sha512_H_0` constant. 1 uses the `H_init` port.

Ports:

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset. It is also routed to the core's `rst`.
- `M_in` in BLOCK_BITS: padded message block, word 0 in the MSBs.
- `in_valid` in 1: `M_in`/`in_last` are valid.
- `in_last` in 1: this block is the final block of the message.
- `in_ready` out 1: the block accepts a block this cycle.
- `H_init` in STATE_BITS: IV, sampled on first-block accept. Ignored when CUSTOM_IV=0.
- `digest` out OUT_BITS: `H[STATE_BITS-1 -: OUT_BITS]` of the final chained state.
- `digest_valid` out 1: `digest` is valid.
- `digest_ready` in 1: consumer takes `digest`.
- `busy` out 1: a message is in progress (state ≠ IDLE).
- `msg_blocks` out 16: number of blocks accepted for the current or last message.

## Operation

- States:
  - IDLE: awaiting the first block.
  - RUN: core computing.
  - NEXT: awaiting a continuation block.
  - DONE: digest held.
- `in_ready` = 1 in IDLE and NEXT only. An accept is `in_valid & in_ready`.
- Accept in IDLE:
  - Latch `M_in` into `m_reg`.
  - Load `h_reg` with the IV (`H_init` or the internal H_0).
  - Set `msg_blocks`=1, record `last_reg`=`in_last`, go to RUN.
- Accept in NEXT:
  - Latch `M_in`; `h_reg` keeps the chained value.
  - Increment `msg_blocks`, saturating at 16'hFFFF.
  - Record `last_reg`, go to RUN.
- RUN:
  - Core `input_valid` pulses high exactly one cycle, the cycle after the accept.
  - Core `H_in`=`h_reg` and `M_in`=`m_reg`, both held stable for the whole of RUN.
  - The first cycle with core `output_valid`=1 while in RUN completes the block. Further core valid cycles are ignored.
- Block completion:
  - `h_reg` ← core `H_out` (the core returns H_in plus the compression result).
  - If `last_reg`=1, go to DONE; otherwise go to NEXT.
- DONE:
  - `digest_valid`=1 and `digest` is driven from `h_reg`, both held stable until `digest_ready`=1.
  - That cycle transitions to IDLE. `in_ready` rises the following cycle; there is no same-cycle bypass.
- `in_valid` outside IDLE/NEXT is ignored. Upstream must hold the block until it is accepted.
- `in_last`=1 on the first block is a single-block message.
- `msg_blocks` holds through DONE and IDLE until the next first-block accept.

## Timing

- Reset values:
  - State = IDLE.
  - `in_ready`=1 (the cycle after `rst` deasserts; 0 while `rst`=1).
  - `digest_valid`=0, `digest`=0, `busy`=0, `msg_blocks`=0.
  - `h_reg` and `m_reg` = 0; core `input_valid`=0.
- Reset mid-operation, in any state:
  - Return to IDLE next edge and discard the in-flight block/digest.
  - The core is reset concurrently, so no stale `output_valid` is honoured.
- Per-block latency, for an accept at edge T:
  - Core `input_valid` is high in cycle T+1.
  - Core result appears at T+1+Lc, where Lc is the core's own latency.
  - The state leaves RUN at the following edge.
  - For the final block, `digest_valid` is high from cycle T+2+Lc.
- Throughput: one block per Lc+2 cycles when upstream keeps `in_valid` high in NEXT.
- Digest backpressure: DONE can last indefinitely. `digest` and `msg_blocks` stay frozen for the whole stall.

## Test plan

- SHA-256 "abc", single padded block (in_last=1), VARIANT=256:
  - Required: `digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad and `msg_blocks`=1.
  - Required: `in_ready`=0 throughout RUN/DONE.
- SHA-256 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", upstream inserting 5 idle cycles between blocks:
  - Required: `digest`=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1 and `msg_blocks`=2.
- VARIANT=512, "abc":
  - Required: `digest`=ddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f.
- VARIANT=256, OUT_BITS=224, CUSTOM_IV=1, `H_init`=c1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4, "abc":
  - Required: `digest`=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7.
- Back-to-back null (SHA-256) and "abc" messages, with `digest_ready` held low 10 cycles on the first:
  - Required: the first `digest`=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, held stable for all 10 cycles.
  - Required: the second message is accepted only after the `digest_ready` handshake, and yields the "abc" digest.
- Assert `rst` for one cycle midway through RUN of the first of two blocks, then send "abc":
  - Required: all outputs are at reset values the cycle after `rst`, and no spurious `digest_valid` appears.
  - Required: the following "abc" digest is correct.

Source files
------------

// File: rtl/sha2_stream.sv
// sha2_stream: multi-block SHA-2 hashing engine with valid/ready handshakes.
// Accepts pre-padded message blocks, drives one sha256_block/sha512_block
// compression core, chains the intermediate hash across blocks and returns
// the (optionally truncated) digest once the final block completes.
//
// Ports (sha2_stream):
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   M_in          : padded message block, word 0 in the MSBs
//   in_valid      : M_in/in_last valid
//   in_last       : block is the final block of the message
//   in_ready      : block accepted this cycle when in_valid is also high
//   H_init        : custom IV, sampled on first-block accept (CUSTOM_IV=1)
//   digest        : H[STATE_BITS-1 -: OUT_BITS] of the final chained state
//   digest_valid  : digest valid, held until digest_ready
//   digest_ready  : consumer takes digest
//   busy          : a message is in progress
//   msg_blocks    : blocks accepted for the current or last message
//
// The file also holds the iterative compression core (one round per clock)
// and its two SHA-256 / SHA-512 wrappers.

module sha2_core #(
  parameter int W      = 32,
  parameter int ROUNDS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            input_valid,
  input  logic [8*W-1:0]  H_in,
  input  logic [16*W-1:0] M_in,
  output logic            output_valid,
  output logic [8*W-1:0]  H_out
);

  // SHA-512 round constants. The SHA-256 constants are the upper 32 bits of
  // the first 64 entries, so a single table serves both word widths.
  localparam logic [63:0] K64 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    int m;
    m = n % W;
    if (m == 0) return x;
    return (x >> m) | (x << (W - m));
  endfunction

  function automatic logic [W-1:0] bsig0(input logic [W-1:0] x);
    if (W == 32) return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    else         return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
  endfunction

  function automatic logic [W-1:0] bsig1(input logic [W-1:0] x);
    if (W == 32) return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    else         return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
  endfunction

  function automatic logic [W-1:0] ssig0(input logic [W-1:0] x);
    if (W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else         return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [W-1:0] ssig1(input logic [W-1:0] x);
    if (W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else         return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  logic         busy;
  logic [6:0]   rnd;
  logic [W-1:0] v   [8];   // working variables a..h
  logic [W-1:0] hin [8];   // chaining input, added back at the end
  logic [W-1:0] w   [16];  // sliding message-schedule window, w[0] = W_t
  logic [W-1:0] kt, t1, t2, w_new;

  always_comb begin
    kt    = K64[rnd][63 -: W];
    t1    = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt + w[0];
    t2    = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    // W_{t+16} from the window; extra words past the last round are unused.
    w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      rnd          <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      if (input_valid && !busy) begin
        busy <= 1'b1;
        rnd  <= '0;
      end else if (busy) begin
        rnd <= rnd + 7'd1;
        if (rnd == LAST_RND) begin
          busy         <= 1'b0;
          output_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (input_valid && !busy) begin
      for (int i = 0; i < 8; i++) begin
        v[i]   <= H_in[8*W-1 - i*W -: W];
        hin[i] <= H_in[8*W-1 - i*W -: W];
      end
      for (int i = 0; i < 16; i++) w[i] <= M_in[16*W-1 - i*W -: W];
    end else if (busy) begin
      v[0] <= t1 + t2;
      v[1] <= v[0];
      v[2] <= v[1];
      v[3] <= v[2];
      v[4] <= v[3] + t1;
      v[5] <= v[4];
      v[6] <= v[5];
      v[7] <= v[6];
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end
  end

  // Final feed-forward; valid in the cycle output_valid is high.
  always_comb begin
    H_out = '0;
    for (int i = 0; i < 8; i++) H_out[8*W-1 - i*W -: W] = hin[i] + v[i];
  end

endmodule

module sha256_block (
  input  logic         clk,
  input  logic         rst,
  input  logic         input_valid,
  input  logic [255:0] H_in,
  input  logic [511:0] M_in,
  output logic         output_valid,
  output logic [255:0] H_out
);
  sha2_core #(.W(32), .ROUNDS(64)) u_core (
    .clk(clk), .rst(rst), .input_valid(input_valid), .H_in(H_in),
    .M_in(M_in), .output_valid(output_valid), .H_out(H_out)
  );
endmodule

module sha512_block (
  input  logic          clk,
  input  logic          rst,
  input  logic          input_valid,
  input  logic [511:0]  H_in,
  input  logic [1023:0] M_in,
  output logic          output_valid,
  output logic [511:0]  H_out
);
  sha2_core #(.W(64), .ROUNDS(80)) u_core (
    .clk(clk), .rst(rst), .input_valid(input_valid), .H_in(H_in),
    .M_in(M_in), .output_valid(output_valid), .H_out(H_out)
  );
endmodule

module sha2_stream #(
  parameter int  VARIANT    = 256,
  parameter int  OUT_BITS   = VARIANT,
  parameter int  CUSTOM_IV  = 0,
  localparam int STATE_BITS = (VARIANT == 512) ? 512 : 256,
  localparam int BLOCK_BITS = 2 * STATE_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BLOCK_BITS-1:0] M_in,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [STATE_BITS-1:0] H_init,
  output logic [OUT_BITS-1:0]   digest,
  output logic                  digest_valid,
  input  logic                  digest_ready,
  output logic                  busy,
  output logic [15:0]           msg_blocks
);

  typedef enum logic [1:0] {IDLE, RUN, NEXT, DONE} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  state_t                state, state_nxt;
  logic [BLOCK_BITS-1:0] m_reg;
  logic [STATE_BITS-1:0] h_reg;
  logic [STATE_BITS-1:0] iv;
  logic [STATE_BITS-1:0] core_h;
  logic                  core_valid;
  logic                  core_start;
  logic                  last_reg;
  logic                  accept;
  logic                  block_done;

  if (OUT_BITS < 1 || OUT_BITS > STATE_BITS) begin : g_bad_out
    $error("sha2_stream: OUT_BITS must be in 1..STATE_BITS");
  end

  if (VARIANT == 256) begin : g_256
    localparam logic [255:0] SHA256_H_0 =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    assign iv = (CUSTOM_IV != 0) ? H_init : SHA256_H_0;
    sha256_block u_core (
      .clk(clk), .rst(rst), .input_valid(core_start), .H_in(h_reg),
      .M_in(m_reg), .output_valid(core_valid), .H_out(core_h)
    );
  end else if (VARIANT == 512) begin : g_512
    localparam logic [511:0] SHA512_H_0 = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    assign iv = (CUSTOM_IV != 0) ? H_init : SHA512_H_0;
    sha512_block u_core (
      .clk(clk), .rst(rst), .input_valid(core_start), .H_in(h_reg),
      .M_in(m_reg), .output_valid(core_valid), .H_out(core_h)
    );
  end else begin : g_bad_variant
    $error("sha2_stream: VARIANT must be 256 or 512");
  end

  // in_ready is forced low while rst is high so nothing is taken during reset.
  assign accept     = in_valid & in_ready;
  assign block_done = (state == RUN) & core_valid;

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    digest_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = RUN;
      end
      RUN: begin
        if (core_valid) state_nxt = last_reg ? DONE : NEXT;
      end
      NEXT: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = RUN;
      end
      DONE: begin
        digest_valid = 1'b1;
        if (digest_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_start <= 1'b0;
      last_reg   <= 1'b0;
      msg_blocks <= '0;
      h_reg      <= '0;
      m_reg      <= '0;
    end else begin
      // One-cycle core start pulse, the cycle after the accept.
      core_start <= accept;
      if (accept) begin
        m_reg    <= M_in;
        last_reg <= in_last;
        if (state == IDLE) begin
          h_reg      <= iv;
          msg_blocks <= 16'd1;
        end else begin
          msg_blocks <= sat_inc16(msg_blocks);
        end
      end
      if (block_done) h_reg <= core_h;
    end
  end

  assign digest = (state == DONE) ? h_reg[STATE_BITS-1 -: OUT_BITS] : '0;

endmodule

// File: tb/tb_sha2_stream.sv
module tb_sha2_stream;

  localparam logic [511:0] ABC256  = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] NULL256 = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B0  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B1  = {448'h0, 64'h1c0};
  localparam logic [1023:0] ABC512 = {32'h61626380, 864'h0, 128'h18};
  localparam logic [255:0] IV224   =
    256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;

  localparam logic [255:0] D_ABC  =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO  =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_NULL =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] D_512  =
    512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [223:0] D_224  =
    224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: SHA-256
  logic [511:0] m_a = '0;
  logic         in_valid_a = 1'b0, in_last_a = 1'b0, dr_a = 1'b0;
  logic [255:0] h_init_a = '0;
  logic         in_ready_a, dv_a, busy_a;
  logic [255:0] digest_a;
  logic [15:0]  mb_a;

  // Instance B: SHA-512
  logic [1023:0] m_b = '0;
  logic          in_valid_b = 1'b0, in_last_b = 1'b0, dr_b = 1'b0;
  logic [511:0]  h_init_b = '0;
  logic          in_ready_b, dv_b, busy_b;
  logic [511:0]  digest_b;
  logic [15:0]   mb_b;

  // Instance C: SHA-224 via custom IV and truncation
  logic [511:0] m_c = '0;
  logic         in_valid_c = 1'b0, in_last_c = 1'b0, dr_c = 1'b0;
  logic [255:0] h_init_c = IV224;
  logic         in_ready_c, dv_c, busy_c;
  logic [223:0] digest_c;
  logic [15:0]  mb_c;

  sha2_stream #(.VARIANT(256)) u_a (
    .clk(clk), .rst(rst), .M_in(m_a), .in_valid(in_valid_a), .in_last(in_last_a),
    .in_ready(in_ready_a), .H_init(h_init_a), .digest(digest_a), .digest_valid(dv_a),
    .digest_ready(dr_a), .busy(busy_a), .msg_blocks(mb_a));

  sha2_stream #(.VARIANT(512)) u_b (
    .clk(clk), .rst(rst), .M_in(m_b), .in_valid(in_valid_b), .in_last(in_last_b),
    .in_ready(in_ready_b), .H_init(h_init_b), .digest(digest_b), .digest_valid(dv_b),
    .digest_ready(dr_b), .busy(busy_b), .msg_blocks(mb_b));

  sha2_stream #(.VARIANT(256), .OUT_BITS(224), .CUSTOM_IV(1)) u_c (
    .clk(clk), .rst(rst), .M_in(m_c), .in_valid(in_valid_c), .in_last(in_last_c),
    .in_ready(in_ready_c), .H_init(h_init_c), .digest(digest_c), .digest_valid(dv_c),
    .digest_ready(dr_c), .busy(busy_c), .msg_blocks(mb_c));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic [511:0] b0;
    logic [511:0] b1;
    int           nblk;
    int           gap;
    logic [255:0] exp_digest;
    logic [15:0]  exp_mb;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present a block and hold it until accepted; returns at the negedge after the accept edge.
  task automatic send_a(input logic [511:0] blk, input logic last);
    bit ok;
    ok = 1'b0;
    m_a = blk; in_last_a = last; in_valid_a = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (in_ready_a) ok = 1'b1;
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    check("send_a accept", ok, 1'b1);
  endtask

  // Wait for digest_valid; flags any in_ready seen while waiting.
  task automatic wait_dv_a(output bit ok, output bit saw_ready);
    ok = 1'b0; saw_ready = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (dv_a) ok = 1'b1;
      else begin
        if (in_ready_a) saw_ready = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic handshake_a();
    dr_a = 1'b1;
    @(negedge clk);
    dr_a = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok, saw, early;

    vecs[0] = '{"abc",         ABC256,  '0,     1, 0, D_ABC,  16'd1};
    vecs[1] = '{"two_gap5",    TWO_B0,  TWO_B1, 2, 5, D_TWO,  16'd2};
    vecs[2] = '{"null",        NULL256, '0,     1, 0, D_NULL, 16'd1};
    vecs[3] = '{"two_b2b",     TWO_B0,  TWO_B1, 2, 0, D_TWO,  16'd2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready_a, 1'b0);
    check("rst digest_valid", dv_a, 1'b0);
    check("rst digest", digest_a, '0);
    check("rst busy", busy_a, 1'b0);
    check("rst msg_blocks", mb_a, 16'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", in_ready_a, 1'b1);
    @(negedge clk);

    // Table-driven SHA-256 messages
    foreach (vecs[k]) begin
      early = 1'b0;
      if (vecs[k].nblk == 2) begin
        send_a(vecs[k].b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
          if (dv_a) early = 1'b1;
          if (in_ready_a) ok = 1'b1;
          else @(negedge clk);
        end
        check({vecs[k].name, " reach NEXT"}, ok, 1'b1);
        check({vecs[k].name, " NEXT busy"}, busy_a, 1'b1);
        repeat (vecs[k].gap) @(negedge clk);
        send_a(vecs[k].b1, 1'b1);
      end else begin
        send_a(vecs[k].b0, 1'b1);
      end
      wait_dv_a(ok, saw);
      check({vecs[k].name, " digest_valid"}, ok, 1'b1);
      check({vecs[k].name, " digest"}, digest_a, vecs[k].exp_digest);
      check({vecs[k].name, " msg_blocks"}, mb_a, vecs[k].exp_mb);
      check({vecs[k].name, " in_ready low RUN/DONE"}, saw, 1'b0);
      check({vecs[k].name, " no early digest"}, early, 1'b0);
      handshake_a();
      check({vecs[k].name, " idle digest_valid"}, dv_a, 1'b0);
      check({vecs[k].name, " idle busy"}, busy_a, 1'b0);
      check({vecs[k].name, " idle msg_blocks held"}, mb_a, vecs[k].exp_mb);
      check({vecs[k].name, " idle digest"}, digest_a, '0);
    end

    // Back-to-back null then abc with 10 cycles of digest backpressure
    send_a(NULL256, 1'b1);
    wait_dv_a(ok, saw);
    check("bp null digest_valid", ok, 1'b1);
    m_a = ABC256; in_last_a = 1'b1; in_valid_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp digest stable", digest_a, D_NULL);
      check("bp valid stable", dv_a, 1'b1);
      check("bp in_ready low", in_ready_a, 1'b0);
      check("bp msg_blocks stable", mb_a, 16'd1);
      @(negedge clk);
    end
    dr_a = 1'b1;
    check("bp handshake digest", digest_a, D_NULL);
    check("bp no bypass", in_ready_a, 1'b0);
    @(negedge clk);
    dr_a = 1'b0;
    check("bp idle in_ready", in_ready_a, 1'b1);
    check("bp idle msg_blocks", mb_a, 16'd1);
    @(negedge clk);
    in_valid_a = 1'b0;
    check("bp second accepted busy", busy_a, 1'b1);
    wait_dv_a(ok, saw);
    check("bp abc digest_valid", ok, 1'b1);
    check("bp abc digest", digest_a, D_ABC);
    check("bp abc msg_blocks", mb_a, 16'd1);
    handshake_a();

    // SHA-512 "abc"
    check("512 in_ready idle", in_ready_b, 1'b1);
    m_b = ABC512; in_last_b = 1'b1; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (dv_b) ok = 1'b1;
      else @(negedge clk);
    end
    check("512 digest_valid", ok, 1'b1);
    check("512 digest", digest_b, D_512);
    check("512 msg_blocks", mb_b, 16'd1);
    dr_b = 1'b1;
    @(negedge clk);
    dr_b = 1'b0;
    check("512 idle busy", busy_b, 1'b0);

    // SHA-224 "abc" via custom IV
    check("224 in_ready idle", in_ready_c, 1'b1);
    m_c = ABC256; in_last_c = 1'b1; in_valid_c = 1'b1;
    @(negedge clk);
    in_valid_c = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (dv_c) ok = 1'b1;
      else @(negedge clk);
    end
    check("224 digest_valid", ok, 1'b1);
    check("224 digest", digest_c, D_224);
    check("224 msg_blocks", mb_c, 16'd1);
    dr_c = 1'b1;
    @(negedge clk);
    dr_c = 1'b0;
    check("224 idle busy", busy_c, 1'b0);

    // Reset midway through RUN of the first of two blocks
    send_a(TWO_B0, 1'b0);
    repeat (10) @(negedge clk);
    check("mid-rst busy before", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid-rst digest_valid", dv_a, 1'b0);
    check("mid-rst digest", digest_a, '0);
    check("mid-rst busy", busy_a, 1'b0);
    check("mid-rst msg_blocks", mb_a, 16'd0);
    check("mid-rst in_ready", in_ready_a, 1'b0);
    rst = 1'b0;
    #1;
    check("mid-rst in_ready after", in_ready_a, 1'b1);
    @(negedge clk);
    saw = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (dv_a || busy_a) saw = 1'b1;
      @(negedge clk);
    end
    check("mid-rst no spurious activity", saw, 1'b0);
    send_a(ABC256, 1'b1);
    wait_dv_a(ok, saw);
    check("mid-rst abc digest_valid", ok, 1'b1);
    check("mid-rst abc digest", digest_a, D_ABC);
    check("mid-rst abc msg_blocks", mb_a, 16'd1);
    handshake_a();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
